// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and default sizing.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int DEF_PC_W    = 10;
    localparam int DEF_INSTR_W = 32;
    localparam int DEF_DEPTH   = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer holding each fetched word together with its PC.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_INSTR_W,
    parameter int PC_W   = DEF_PC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic [PC_W-1:0]          push_pc,
    input  logic                     pop,
    output logic                     valid,
    output logic [DATA_W-1:0]        head_data,
    output logic [PC_W-1:0]          head_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_V = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       cnt;
    logic              push_ok;
    logic              pop_ok;

    assign push_ok = push && (cnt != FULL_V);
    assign pop_ok  = pop && (cnt != '0);

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is data only; it needs no reset because the head is masked when empty.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            data_mem[wr_ptr] <= push_data;
            pc_mem[wr_ptr]   <= push_pc;
        end
    end

    assign valid     = (cnt != '0);
    assign head_data = valid ? data_mem[rd_ptr] : '0;
    assign head_pc   = valid ? pc_mem[rd_ptr] : '0;
    assign count     = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential fetches, buffers in-order responses,
// and discards responses made stale by a redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = DEF_PC_W,
    parameter int              INSTR_W  = DEF_INSTR_W,
    parameter int              DEPTH    = DEF_DEPTH,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [PC_W-1:0]    instr_pc
);

    localparam int              CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]  DEPTH_V = (CNT_W+1)'(DEPTH);
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);
    localparam logic [PC_W-1:0] ALIGN_M = ~PC_W'(3);

    state_t            state;
    state_t            state_next;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_next;
    logic [PC_W-1:0]   rsp_pc;
    logic [PC_W-1:0]   rsp_pc_next;
    logic [PC_W-1:0]   target;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  outstanding_next;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  drop_cnt_next;
    logic [CNT_W-1:0]  buf_count;
    logic [CNT_W:0]    in_use;
    logic              accept;
    logic              rsp_taken;
    logic              enq;
    logic              deq;
    logic              buf_valid;

    assign target    = redirect_pc & ALIGN_M;
    assign in_use    = {1'b0, buf_count} + {1'b0, outstanding};

    // Buffered plus in-flight never exceeds DEPTH, so every response has a free slot.
    assign imem_req_valid = (state == FETCH) && (in_use < DEPTH_V);
    assign imem_addr      = pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign rsp_taken      = imem_rsp_valid && (outstanding != '0);
    assign enq            = imem_rsp_valid && (state == FETCH) && !redirect_valid;
    assign deq            = buf_valid && instr_ready && !redirect_valid;
    assign instr_valid    = buf_valid;

    always_comb begin
        outstanding_next = outstanding;
        case ({accept, rsp_taken})
            2'b10:   outstanding_next = outstanding + 1'b1;
            2'b01:   outstanding_next = outstanding - 1'b1;
            default: outstanding_next = outstanding;
        endcase
    end

    // rsp_pc tracks the PC of the oldest live request: live requests are always a
    // sequential run starting at the last redirect target, so no tag queue is needed.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        rsp_pc_next   = rsp_pc;
        drop_cnt_next = drop_cnt;
        case (state)
            BOOT: begin
                state_next = FETCH;
                if (redirect_valid) begin
                    pc_next     = target;
                    rsp_pc_next = target;
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    pc_next       = target;
                    rsp_pc_next   = target;
                    drop_cnt_next = outstanding_next;
                    state_next    = (outstanding_next != '0) ? FLUSH : FETCH;
                end else begin
                    if (accept) pc_next     = pc + PC_STEP;
                    if (enq)    rsp_pc_next = rsp_pc + PC_STEP;
                end
            end
            FLUSH: begin
                if (redirect_valid) begin
                    pc_next     = target;
                    rsp_pc_next = target;
                end
                if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt_next = drop_cnt - 1'b1;
                if (drop_cnt_next == '0) state_next = FETCH;
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            rsp_pc      <= rsp_pc_next;
            outstanding <= outstanding_next;
            drop_cnt    <= drop_cnt_next;
        end
    end

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (INSTR_W),
        .PC_W   (PC_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (enq),
        .push_data (imem_rsp_data),
        .push_pc   (rsp_pc),
        .pop       (deq),
        .valid     (buf_valid),
        .head_data (instr_data),
        .head_pc   (instr_pc),
        .count     (buf_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory with random latency and an architectural
// reference model of the fetch stream, buffer occupancy and stale responses.
module tb_fetch_unit;

    localparam int          PC_W     = 10;
    localparam int          INSTR_W  = 32;
    localparam int          DEPTH    = 4;
    localparam logic [9:0]  RESET_PC = 10'h000;

    logic               clk;
    logic               reset;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr_data;
    logic [PC_W-1:0]    instr_pc;

    fetch_unit #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] addr;
        bit         stale;
        int         due;
    } req_t;

    req_t       inflight[$];
    logic [9:0] acc_log[$];
    int         checks;
    int         errors;
    int         cyc;
    int         buffered;
    bit         boot;
    logic [9:0] exp_pc;
    logic [9:0] exp_fetch;
    int         p_req;
    int         p_ins;
    int         lat_min;
    int         lat_max;
    int         n_acc;
    bit         saw_100;
    bit         found;

    function automatic logic [31:0] memf(input logic [9:0] a);
        return {6'h2B, a, 6'h15, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int stale_cnt();
        int n = 0;
        foreach (inflight[i]) if (inflight[i].stale) n++;
        return n;
    endfunction

    // One clock cycle: check outputs against the model, drive inputs, advance the model.
    task automatic step(input bit rst_n, input bit rd, input logic [9:0] tgt);
        bit exp_rv;
        bit acc;
        bit dq;
        bit rsp;
        int lat;
        exp_rv = !boot && (stale_cnt() == 0) && ((buffered + inflight.size()) < DEPTH);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("imem_addr", 32'(imem_addr), 32'(exp_fetch));
        chk("instr_valid", 32'(instr_valid), 32'(buffered > 0));
        if (buffered > 0) begin
            chk("instr_pc", 32'(instr_pc), 32'(exp_pc));
            chk("instr_data", instr_data, memf(exp_pc));
        end
        if (boot) begin
            chk("reset_data", instr_data, 32'h0);
            chk("reset_pc", 32'(instr_pc), 32'h0);
        end

        reset          = rst_n;
        redirect_valid = rd;
        redirect_pc    = rd ? tgt : 10'($urandom);
        imem_req_ready = ($urandom_range(99) < p_req);
        instr_ready    = ($urandom_range(99) < p_ins);
        if (inflight.size() > 0 && inflight[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(inflight[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        acc = imem_req_valid && imem_req_ready;
        dq  = instr_valid && instr_ready;
        rsp = imem_rsp_valid;
        if (acc && rst_n) begin
            acc_log.push_back(imem_addr);
            if (imem_addr == 10'h100) saw_100 = 1'b1;
        end
        @(posedge clk);
        if (!rst_n) begin
            inflight.delete();
            buffered  = 0;
            exp_pc    = RESET_PC;
            exp_fetch = RESET_PC;
            boot      = 1'b1;
        end else begin
            boot = 1'b0;
            if (rsp) begin
                if (!inflight[0].stale && !rd) buffered++;
                void'(inflight.pop_front());
            end
            if (dq && !rd) begin
                buffered--;
                exp_pc = exp_pc + 10'd4;
            end
            if (acc) begin
                lat = $urandom_range(lat_max, lat_min);
                inflight.push_back('{exp_fetch, rd, cyc + lat});
                n_acc++;
                exp_fetch = exp_fetch + 10'd4;
            end
            if (rd) begin
                exp_fetch = tgt & 10'h3FC;
                exp_pc    = tgt & 10'h3FC;
                buffered  = 0;
                foreach (inflight[i]) inflight[i].stale = 1'b1;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; buffered = 0; boot = 1'b1;
        exp_pc = RESET_PC; exp_fetch = RESET_PC;
        p_req = 100; p_ins = 100; lat_min = 1; lat_max = 1;
        n_acc = 0; saw_100 = 1'b0; found = 1'b0;
        reset = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset held, then release with always-ready 1-cycle memory
        step(1'b0, 1'b0, 10'h0);
        step(1'b0, 1'b0, 10'h0);
        acc_log.delete();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 10'h0);
        chk("boot_first_addr", 32'(acc_log[0]), 32'h000);
        chk("boot_second_addr", 32'(acc_log[1]), 32'h004);
        chk("boot_third_addr", 32'(acc_log[2]), 32'h008);

        // Back-pressure: consumer stalled, exactly DEPTH requests after redirect
        p_ins = 0;
        step(1'b1, 1'b1, 10'h040);
        n_acc = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 10'h0);
        chk("bp_req_count", 32'(n_acc), 32'(DEPTH));
        p_ins = 100;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 10'h0);

        // Redirect with two requests in flight
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 10'h0);
        chk("stale_inflight", 32'(inflight.size()), 32'd2);
        step(1'b1, 1'b1, 10'h100);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 10'h0);

        // Second redirect while flushing
        lat_min = 4; lat_max = 4;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 10'h0);
        step(1'b1, 1'b1, 10'h100);
        saw_100 = 1'b0;
        acc_log.delete();
        step(1'b1, 1'b1, 10'h200);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 10'h0);
        chk("flush_no_0x100", 32'(saw_100), 32'd0);
        chk("flush_resume", 32'(acc_log.size() > 0 ? acc_log[0] : 10'h3FF), 32'h200);

        // Wrap at the top of the address space, then a misaligned target
        lat_min = 1; lat_max = 1;
        step(1'b1, 1'b1, 10'h3F8);
        acc_log.delete();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 10'h0);
        chk("wrap_addr", 32'(acc_log.size() > 2 ? acc_log[2] : 10'h3FF), 32'h000);
        step(1'b1, 1'b1, 10'h103);
        acc_log.delete();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 10'h0);
        chk("misaligned_target", 32'(acc_log.size() > 0 ? acc_log[0] : 10'h3FF), 32'h100);

        // Reset with the buffer at 3 of 4 and one request in flight
        p_ins = 0; lat_min = 2; lat_max = 2;
        step(1'b1, 1'b1, 10'h080);
        for (int i = 0; i < 40 && !found; i++) begin
            if (buffered == 3 && inflight.size() == 1) found = 1'b1;
            else step(1'b1, 1'b0, 10'h0);
        end
        chk("midreset_setup", 32'(found), 32'd1);
        step(1'b0, 1'b0, 10'h0);
        chk("midreset_instr_valid", 32'(instr_valid), 32'd0);
        step(1'b1, 1'b0, 10'h0);
        chk("midreset_addr", 32'(imem_addr), 32'(RESET_PC));
        chk("midreset_req_valid", 32'(imem_req_valid), 32'd1);
        p_ins = 100;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 10'h0);

        // Randomized traffic with redirects and occasional resets
        for (int i = 0; i < 2500; i++) begin
            if (i % 100 == 0) begin
                p_req   = $urandom_range(100, 30);
                p_ins   = $urandom_range(100, 0);
                lat_min = 1;
                lat_max = $urandom_range(5, 1);
            end
            step(!($urandom_range(999) < 5), ($urandom_range(99) < 4), 10'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 10, meaning byte-address width of the PC.
REQ-002 The block SHALL have parameter INSTR_W, default 32, meaning instruction width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning instruction-buffer entries; legal values are powers of 2 and at least 2.
REQ-004 The block SHALL have parameter RESET_PC, default 0, meaning the first fetch address.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port imem_req_valid, output, 1 bit: a fetch request is presented.
REQ-008 The block SHALL have port imem_req_ready, input, 1 bit: memory accepts the request.
REQ-009 The block SHALL have port imem_addr, output, PC_W bits: the fetch byte address.
REQ-010 The block SHALL have port imem_rsp_valid, input, 1 bit: response data is valid; responses are in order, with latency of 1 or more cycles.
REQ-011 The block SHALL have port imem_rsp_data, input, INSTR_W bits: the fetched instruction.
REQ-012 The block SHALL have port redirect_valid, input, 1 bit: a branch/jump redirect.
REQ-013 The block SHALL have port redirect_pc, input, PC_W bits: the redirect target.
REQ-014 The block SHALL have port instr_valid, output, 1 bit: the buffer head is valid.
REQ-015 The block SHALL have port instr_ready, input, 1 bit: downstream consumes the head.
REQ-016 The block SHALL have port instr_data, output, INSTR_W bits: the head instruction.
REQ-017 The block SHALL have port instr_pc, output, PC_W bits: the head instruction's address.

Function
REQ-018 PC handling SHALL be as follows: the PC is a byte address; sequential fetch adds 4, modulo 2^PC_W, and wraps silently; redirect_pc[1:0] is forced to 0.
REQ-019 The state machine SHALL have states BOOT, FETCH and FLUSH; BOOT lasts exactly one cycle after reset release, then moves to FETCH.
REQ-020 A request SHALL be accepted when imem_req_valid and imem_req_ready are both high; imem_addr and imem_req_valid hold stable until acceptance.
REQ-021 In FETCH, imem_req_valid SHALL be high only while buffer count plus outstanding requests is less than DEPTH, so the buffer can never overflow.
REQ-022 In BOOT and FLUSH, imem_req_valid SHALL be 0.
REQ-023 A non-stale response SHALL be written to the buffer tail in the cycle imem_rsp_valid is high, tagged with its request PC; it becomes visible on instr_* the next cycle.
REQ-024 A dequeue SHALL occur when instr_valid and instr_ready are both high; a simultaneous enqueue and dequeue leaves the count unchanged.
REQ-025 On redirect_valid, the buffer SHALL be flushed, PC set to redirect_pc, and drop_cnt set to outstanding, including any request accepted and any response arriving in the same cycle, which are counted as stale.
REQ-026 After a redirect, the state SHALL be FLUSH if drop_cnt is non-zero, otherwise FETCH.
REQ-027 In FLUSH, each imem_rsp_valid SHALL be discarded and decrement drop_cnt; when the count reaches 0 (including a decrement in that cycle), the state moves to FETCH on the next cycle.
REQ-028 A redirect during FLUSH SHALL update PC only; drop_cnt is unchanged and the state remains FLUSH.
REQ-029 A redirect in the same cycle as a dequeue handshake SHALL count that instruction as consumed.
REQ-030 Redirect SHALL have priority over all other events in the same cycle.
REQ-031 A redirect arriving in BOOT SHALL set PC; the block still goes to FETCH.
REQ-032 Outstanding and drop counters SHALL be clog2(DEPTH)+1 bits wide and SHALL never underflow.

Reset
REQ-033 While reset is 0 at a clock edge, the block SHALL set state=BOOT, PC=RESET_PC, buffer empty, outstanding=0 and drop_cnt=0.
REQ-034 While reset is 0 at a clock edge, the block SHALL drive imem_req_valid=0 and instr_valid=0, and instr_data and instr_pc to 0.
REQ-035 Reset mid-operation SHALL abandon in-flight requests; the environment resets memory in the same cycle.

Structure
REQ-036 Package fetch_pkg SHALL hold the state encoding (BOOT/FETCH/FLUSH) and the default PC_W, INSTR_W and DEPTH values.
REQ-037 The buffer SHALL be a sub-module fetch_fifo (synchronous FIFO; data plus PC; parameter DEPTH; reset shared with the parent).

Verification
REQ-038 Scenario reset release: memory always ready with 1-cycle latency -> BOOT for 1 cycle; imem_addr sequence 0x000, 0x004, 0x008; instr_pc follows the same sequence.
REQ-039 Scenario back-pressure: instr_ready=0 with DEPTH=4 -> exactly 4 requests issued; imem_req_valid=0 afterward; no buffer entry lost.
REQ-040 Scenario redirect with stale responses: redirect to 0x100 while 2 requests are outstanding -> both responses dropped; instr_valid=0 until the 0x100 instruction returns; first instr_pc=0x100.
REQ-041 Scenario redirect during FLUSH: second redirect to 0x200 during FLUSH -> fetch resumes at 0x200; 0x100 is never fetched.
REQ-042 Scenario wrap and misaligned target: PC_W=10, PC=0x3FC -> next address 0x000; redirect_pc=0x103 -> fetch at 0x100.
REQ-043 Scenario reset mid-operation: reset=0 while FIFO is at 3/4 with 1 outstanding -> next cycle instr_valid=0, state BOOT, then imem_addr=RESET_PC.
